// File: rtl/serial_sample_table.sv
`default_nettype none
// ============================================================================
// Module   : serial_sample_table
// Purpose  : Sample store for the serial genetic-circuit evaluator. Holds
//            NUM_SAMPLES entries, each made of an input sequence, an
//            expected-output sequence and a valid-output mask. Entries are
//            loaded one at a time through a prepare/write handshake. They are
//            read back through a registered random-access port.
// Ports    : iClock/iReset/iClear     - clock, sync reset, sync table clear
//            iPreparingNextSample     - producer starts an entry
//            iWriteSample/iSampleIndex/iCurrentSerial* - write strobe and data
//            oNextSample              - block is idle and ready for an entry
//            oLoadError               - one-cycle pulse on out-of-range write
//            oSampleCount/oAllLoaded  - distinct loaded entries
//            iRdEn/iRdIndex           - read request
//            oRdValid/oRdLoaded/oRd*  - registered read response
// Option   : SERIAL_SAMPLE_TABLE_DEBUG_EN adds oVerificacao[NUM_SAMPLES-1:0]
//            (bit 1 of byte 0 of each entry's expected output).
// Revision : 1.0 - initial release
// ============================================================================
module serial_sample_table #(
  parameter int NUM_SAMPLES = 24,
  parameter int SEQ_LEN     = 4,
  parameter int BYTE_W      = 8,
  parameter int IDX_W       = 32
) (
  input  logic                               iClock,
  input  logic                               iReset,
  input  logic                               iClear,
  input  logic                               iPreparingNextSample,
  input  logic                               iWriteSample,
  input  logic [IDX_W-1:0]                   iSampleIndex,
  input  logic [SEQ_LEN*BYTE_W-1:0]          iCurrentSerialInput,
  input  logic [SEQ_LEN*BYTE_W-1:0]          iCurrentSerialExpectedOutput,
  input  logic [SEQ_LEN*BYTE_W-1:0]          iCurrentSerialValidOutput,
  output logic                               oNextSample,
  output logic                               oLoadError,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]   oSampleCount,
  output logic                               oAllLoaded,
  input  logic                               iRdEn,
  input  logic [IDX_W-1:0]                   iRdIndex,
  output logic                               oRdValid,
  output logic                               oRdLoaded,
  output logic [SEQ_LEN*BYTE_W-1:0]          oRdInput,
  output logic [SEQ_LEN*BYTE_W-1:0]          oRdExpected,
`ifdef SERIAL_SAMPLE_TABLE_DEBUG_EN
  output logic [SEQ_LEN*BYTE_W-1:0]          oRdValidMask,
  output logic [NUM_SAMPLES-1:0]             oVerificacao
`else
  output logic [SEQ_LEN*BYTE_W-1:0]          oRdValidMask
`endif
);

  localparam int DW = SEQ_LEN * BYTE_W;
  localparam int AW = $clog2(NUM_SAMPLES);
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [IDX_W-1:0] C_NUM_IDX = IDX_W'(NUM_SAMPLES);
  localparam logic [CW-1:0]    C_NUM_CNT = CW'(NUM_SAMPLES);

  typedef enum logic [0:0] {
    SEQ_IDLE       = 1'b0,
    WAITING_SAMPLE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          in_q  [NUM_SAMPLES];
  logic [DW-1:0]          in_d  [NUM_SAMPLES];
  logic [DW-1:0]          exp_q [NUM_SAMPLES];
  logic [DW-1:0]          exp_d [NUM_SAMPLES];
  logic [DW-1:0]          vm_q  [NUM_SAMPLES];
  logic [DW-1:0]          vm_d  [NUM_SAMPLES];
  logic [NUM_SAMPLES-1:0] loaded_q, loaded_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   load_err_q, load_err_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_loaded_q, rd_loaded_d;
  logic [DW-1:0]          rd_in_q, rd_in_d;
  logic [DW-1:0]          rd_exp_q, rd_exp_d;
  logic [DW-1:0]          rd_vm_q, rd_vm_d;

  // Range checks use the full index width so huge indices never alias.
  logic          w_wr_in_range;
  logic          w_rd_in_range;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  assign w_wr_in_range = (iSampleIndex < C_NUM_IDX);
  assign w_rd_in_range = (iRdIndex < C_NUM_IDX);
  assign w_wr_addr     = iSampleIndex[AW-1:0];
  assign w_rd_addr     = iRdIndex[AW-1:0];

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    exp_d       = exp_q;
    vm_d        = vm_q;
    loaded_d    = loaded_q;
    count_d     = count_q;
    load_err_d  = 1'b0;
    rd_valid_d  = iRdEn;
    rd_loaded_d = rd_loaded_q;
    rd_in_d     = rd_in_q;
    rd_exp_d    = rd_exp_q;
    rd_vm_d     = rd_vm_q;

    // Read samples the current (pre-write) table contents.
    if (iRdEn) begin
      rd_loaded_d = 1'b0;
      rd_in_d     = '0;
      rd_exp_d    = '0;
      rd_vm_d     = '0;
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        if (w_rd_in_range && (w_rd_addr == AW'(k)) && loaded_q[k]) begin
          rd_loaded_d = 1'b1;
          rd_in_d     = in_q[k];
          rd_exp_d    = exp_q[k];
          rd_vm_d     = vm_q[k];
        end
      end
    end

    case (state_q)
      SEQ_IDLE: begin
        if (iPreparingNextSample) begin
          state_d = WAITING_SAMPLE;
        end
      end
      WAITING_SAMPLE: begin
        if (iWriteSample) begin
          state_d = SEQ_IDLE;
          if (w_wr_in_range) begin
            for (int k = 0; k < NUM_SAMPLES; k++) begin
              if (w_wr_addr == AW'(k)) begin
                in_d[k]     = iCurrentSerialInput;
                exp_d[k]    = iCurrentSerialExpectedOutput;
                vm_d[k]     = iCurrentSerialValidOutput;
                loaded_d[k] = 1'b1;
                // Only first-time loads count, so the count saturates at
                // NUM_SAMPLES by construction.
                if (!loaded_q[k]) begin
                  count_d = count_q + CW'(1);
                end
              end
            end
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Clear wipes the table and abandons any pending write; read-port
    // registers are left alone so a read in flight still completes.
    if (iClear) begin
      state_d    = SEQ_IDLE;
      loaded_d   = '0;
      count_d    = '0;
      load_err_d = 1'b0;
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        in_d[k]  = '0;
        exp_d[k] = '0;
        vm_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= SEQ_IDLE;
      in_q        <= '{default: '0};
      exp_q       <= '{default: '0};
      vm_q        <= '{default: '0};
      loaded_q    <= '0;
      count_q     <= '0;
      load_err_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_loaded_q <= 1'b0;
      rd_in_q     <= '0;
      rd_exp_q    <= '0;
      rd_vm_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      exp_q       <= exp_d;
      vm_q        <= vm_d;
      loaded_q    <= loaded_d;
      count_q     <= count_d;
      load_err_q  <= load_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_loaded_q <= rd_loaded_d;
      rd_in_q     <= rd_in_d;
      rd_exp_q    <= rd_exp_d;
      rd_vm_q     <= rd_vm_d;
    end
  end

  assign oNextSample  = (state_q == SEQ_IDLE);
  assign oLoadError   = load_err_q;
  assign oSampleCount = count_q;
  assign oAllLoaded   = (count_q == C_NUM_CNT);
  assign oRdValid     = rd_valid_q;
  assign oRdLoaded    = rd_loaded_q;
  assign oRdInput     = rd_in_q;
  assign oRdExpected  = rd_exp_q;
  assign oRdValidMask = rd_vm_q;

`ifdef SERIAL_SAMPLE_TABLE_DEBUG_EN
  // Unloaded entries hold zero data, so no explicit masking is needed.
  for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_verificacao
    assign oVerificacao[k] = exp_q[k][1];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_sample_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sample_table
// Purpose  : Self-checking bench for serial_sample_table. A table of write
//            vectors carries the expected error flag and count. A small
//            reference model predicts read data. Read responses are checked
//            from a scoreboard queue as they emerge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sample_table;

  localparam int N  = 24;
  localparam int DW = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          iReset = 1'b1, iClear = 1'b0;
  logic          iPreparingNextSample = 1'b0, iWriteSample = 1'b0;
  logic [31:0]   iSampleIndex = '0;
  logic [DW-1:0] iIn = '0, iExp = '0, iVm = '0;
  logic          iRdEn = 1'b0;
  logic [31:0]   iRdIndex = '0;
  logic          oNextSample, oLoadError, oAllLoaded, oRdValid, oRdLoaded;
  logic [CW-1:0] oSampleCount;
  logic [DW-1:0] oRdInput, oRdExpected, oRdValidMask;
`ifdef SERIAL_SAMPLE_TABLE_DEBUG_EN
  logic [N-1:0]  oVerificacao;
`endif

  serial_sample_table #(.NUM_SAMPLES(N), .SEQ_LEN(4), .BYTE_W(8), .IDX_W(32)) dut (
    .iClock                       (clk),
    .iReset                       (iReset),
    .iClear                       (iClear),
    .iPreparingNextSample         (iPreparingNextSample),
    .iWriteSample                 (iWriteSample),
    .iSampleIndex                 (iSampleIndex),
    .iCurrentSerialInput          (iIn),
    .iCurrentSerialExpectedOutput (iExp),
    .iCurrentSerialValidOutput    (iVm),
    .oNextSample                  (oNextSample),
    .oLoadError                   (oLoadError),
    .oSampleCount                 (oSampleCount),
    .oAllLoaded                   (oAllLoaded),
    .iRdEn                        (iRdEn),
    .iRdIndex                     (iRdIndex),
    .oRdValid                     (oRdValid),
    .oRdLoaded                    (oRdLoaded),
    .oRdInput                     (oRdInput),
    .oRdExpected                  (oRdExpected),
`ifdef SERIAL_SAMPLE_TABLE_DEBUG_EN
    .oRdValidMask                 (oRdValidMask),
    .oVerificacao                 (oVerificacao)
`else
    .oRdValidMask                 (oRdValidMask)
`endif
  );

  typedef struct {
    logic [31:0] idx;
    logic [31:0] din;
    logic [31:0] dexp;
    logic [31:0] dvm;
    logic        err;
    int          cnt;
  } vec_t;

  typedef struct {
    logic        ld;
    logic [31:0] din;
    logic [31:0] dexp;
    logic [31:0] dvm;
  } rd_t;

  vec_t        vecs[27];
  rd_t         sb[$];
  logic [31:0] m_in[N], m_exp[N], m_vm[N];
  logic        m_ld[N];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_in[k] = '0; m_exp[k] = '0; m_vm[k] = '0; m_ld[k] = 1'b0;
    end
  endtask

  // Drive a read request for the coming edge and predict its response.
  task automatic push_read(input logic [31:0] idx);
    rd_t r;
    r = '{ld: 1'b0, din: '0, dexp: '0, dvm: '0};
    if (idx < N && m_ld[idx]) begin
      r = '{ld: 1'b1, din: m_in[idx], dexp: m_exp[idx], dvm: m_vm[idx]};
    end
    iRdEn    = 1'b1;
    iRdIndex = idx;
    sb.push_back(r);
  endtask

  task automatic rd(input logic [31:0] idx);
    push_read(idx);
    tick();
    iRdEn = 1'b0;
  endtask

  // Full prepare/write handshake, optionally with a same-cycle read.
  task automatic wr(input vec_t v, input logic do_rd, input logic [31:0] rd_idx);
    iPreparingNextSample = 1'b1;
    tick();
    iPreparingNextSample = 1'b0;
    chk("next_sample_waiting", oNextSample, 1'b0);
    iWriteSample = 1'b1;
    iSampleIndex = v.idx;
    iIn = v.din; iExp = v.dexp; iVm = v.dvm;
    if (do_rd) push_read(rd_idx);
    tick();
    iWriteSample = 1'b0;
    iRdEn        = 1'b0;
    if (v.idx < N) begin
      m_in[v.idx] = v.din; m_exp[v.idx] = v.dexp; m_vm[v.idx] = v.dvm;
      m_ld[v.idx] = 1'b1;
    end
    chk("load_error", oLoadError, v.err);
    chk("sample_count", oSampleCount, v.cnt);
    chk("all_loaded", oAllLoaded, (v.cnt == N));
    chk("next_sample_idle", oNextSample, 1'b1);
    if (v.err) begin
      tick();
      chk("load_error_pulse_end", oLoadError, 1'b0);
    end
  endtask

  // Read-response checker: every oRdValid cycle must match the oldest
  // prediction.
  always @(negedge clk) begin
    if (oRdValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected_valid", 1'b1, 1'b0);
      end else begin
        rd_t r;
        r = sb.pop_front();
        chk("rd_loaded", oRdLoaded, r.ld);
        chk("rd_input", oRdInput, r.din);
        chk("rd_expected", oRdExpected, r.dexp);
        chk("rd_valid_mask", oRdValidMask, r.dvm);
      end
    end
  end

  initial begin
    vec_t v;
    model_clear();
    for (int i = 0; i < N; i++) begin
      vecs[i] = '{idx: i, din: 32'hC0DE0000 | i,
                  dexp: (i == 7) ? 32'h0000_00AA : (32'h0000_0100 | i),
                  dvm: ~(32'h1 << i), err: 1'b0,
                  cnt: (i < 5) ? i + 2 : i + 1};
    end
    vecs[24] = '{idx: 3, din: 32'hDEADBEEF, dexp: 32'h3333_3333, dvm: 32'h0F0F0F0F, err: 1'b0, cnt: N};
    vecs[25] = '{idx: 24, din: 32'h1, dexp: 32'h2, dvm: 32'h3, err: 1'b1, cnt: N};
    vecs[26] = '{idx: 32'hFFFF_FFFF, din: 32'h4, dexp: 32'h5, dvm: 32'h6, err: 1'b1, cnt: N};

    // Reset, then idle.
    tick(); tick();
    iReset = 1'b0;
    tick(); tick(); tick();
    chk("rst_next_sample", oNextSample, 1'b1);
    chk("rst_count", oSampleCount, 0);
    chk("rst_all_loaded", oAllLoaded, 1'b0);
    chk("rst_rd_valid", oRdValid, 1'b0);
    chk("rst_rd_loaded", oRdLoaded, 1'b0);
    chk("rst_load_error", oLoadError, 1'b0);
    chk("rst_rd_expected", oRdExpected, 32'h0);

    // Single load of index 5 and read-back.
    v = '{idx: 5, din: 32'h11223344, dexp: 32'h000000FF, dvm: 32'hFFFFFFFF, err: 1'b0, cnt: 1};
    wr(v, 1'b0, 0);
    rd(5);
    rd(6);

    // Table: fill all entries, rewrite one, two out-of-range writes.
    for (int i = 0; i < 27; i++) begin
      wr(vecs[i], 1'b0, 0);
    end
    rd(3); rd(23); rd(24); rd(32'hFFFF_FFFF); rd(0);

    // Same-cycle read and write of index 7 returns the old data.
    v = '{idx: 7, din: 32'h7777_0007, dexp: 32'h0000_0055, dvm: 32'h00FF00FF, err: 1'b0, cnt: N};
    wr(v, 1'b1, 7);
    rd(7);

    // Clear with a pending write in WAITING_SAMPLE.
    iPreparingNextSample = 1'b1;
    tick();
    iPreparingNextSample = 1'b0;
    iWriteSample = 1'b1; iClear = 1'b1; iSampleIndex = 2;
    iIn = 32'h9999_9999; iExp = 32'h8888_8888; iVm = 32'h7777_7777;
    tick();
    iWriteSample = 1'b0; iClear = 1'b0;
    model_clear();
    chk("clr_count", oSampleCount, 0);
    chk("clr_all_loaded", oAllLoaded, 1'b0);
    chk("clr_next_sample", oNextSample, 1'b1);
    chk("clr_load_error", oLoadError, 1'b0);
    rd(2); rd(7); rd(0);

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/serial_sample_table.md
Name: serial_sample_table

Overview:
- Parametrised sample store for the serial genetic-circuit evaluator.
- Holds NUM_SAMPLES entries. Each entry has three fields: an input sequence, an expected-output sequence and a valid-output mask, each SEQ_LEN bytes.
- Entries are loaded one at a time from the sample-generation FSM through a prepare/write handshake.
- Entries are read back by the fitness evaluator through a registered random-access read port. The block tracks a per-entry loaded flag and a load count.

Parameters:
- NUM_SAMPLES, 24, number of table entries (≥2)
- SEQ_LEN, 4, bytes per sequence field
- BYTE_W, 8, bits per byte
- IDX_W, 32, width of the index inputs

Ports:
- iClock  in  1  clock
- iReset  in  1  synchronous active-high reset
- iClear  in  1  synchronous table clear (same effect as reset, except outputs named below)
- iPreparingNextSample  in  1  producer is preparing an entry
- iWriteSample  in  1  write strobe, sampled in WAITING_SAMPLE
- iSampleIndex  in  IDX_W  target entry of the write
- iCurrentSerialInput  in  SEQ_LEN*BYTE_W  input sequence
- iCurrentSerialExpectedOutput  in  SEQ_LEN*BYTE_W  expected output sequence
- iCurrentSerialValidOutput  in  SEQ_LEN*BYTE_W  valid-output mask
- oNextSample  out  1  high while in SEQ_IDLE
- oLoadError  out  1  one-cycle pulse on an out-of-range write
- oSampleCount  out  $clog2(NUM_SAMPLES+1)  number of distinct loaded entries
- oAllLoaded  out  1  oSampleCount == NUM_SAMPLES
- iRdEn  in  1  read request
- iRdIndex  in  IDX_W  read entry
- oRdValid  out  1  read data valid, one cycle after iRdEn
- oRdLoaded  out  1  the entry read was loaded
- oRdInput / oRdExpected / oRdValidMask  out  SEQ_LEN*BYTE_W each  read data

Behaviour:
- Reset (iReset=1 at a clock edge):
  - State goes to SEQ_IDLE.
  - All loaded flags = 0, all data = 0.
  - oSampleCount=0, oAllLoaded=0, oLoadError=0, oRdValid=0, oRdLoaded=0, all oRd* data = 0.
  - oNextSample=1 in the first cycle after reset.
- iClear:
  - Identical to reset for state, flags, data and count.
  - oRdValid, oRdLoaded and oRd* data are not affected.
  - Priority: iReset > iClear > write.
- State machine SEQ_IDLE:
  - oNextSample=1.
  - iPreparingNextSample=1 → WAITING_SAMPLE next cycle.
  - iWriteSample is ignored in SEQ_IDLE.
- State machine WAITING_SAMPLE:
  - oNextSample=0.
  - Holds until iWriteSample=1.
  - On iWriteSample=1 with iSampleIndex<NUM_SAMPLES:
    - The three fields are written to the entry.
    - The loaded flag is set.
    - oSampleCount increments only if the flag was previously 0. A re-write overwrites the data with no count change.
    - → SEQ_IDLE.
  - On iWriteSample=1 with iSampleIndex≥NUM_SAMPLES:
    - Nothing is written.
    - oLoadError=1 for exactly the next cycle.
    - → SEQ_IDLE.
- Write latency: data is visible to a read issued in the cycle after the write edge.
- Read port:
  - iRdEn=1 registers one entry; oRdValid=1 the next cycle and 0 otherwise.
  - Unloaded or out-of-range index: oRdLoaded=0 and data = 0.
  - Read and write to the same index in the same cycle: the read returns the pre-write contents.
  - Reads are legal in any state, including during iClear.
- oAllLoaded is combinational from oSampleCount.
- Count saturation: oSampleCount cannot exceed NUM_SAMPLES, because distinct-entry counting bounds it.
- Reset or clear while in WAITING_SAMPLE abandons the pending write.

Optional Feature:
- Macro: SERIAL_SAMPLE_TABLE_DEBUG_EN.
- Defined:
  - Adds output oVerificacao [NUM_SAMPLES-1:0].
  - Bit k = bit 1 of byte 0 of entry k's expected output (zero when not loaded). Registered with the table.
  - Used for board LEDs and signal-tap.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle 3 cycles → oNextSample=1, oSampleCount=0, oAllLoaded=0, oRdValid=0.
- Load index 5 with input=0x11223344, expected=0x000000FF, valid=0xFFFFFFFF; read 5 next cycle → oRdValid=1, oRdLoaded=1, data matches, oSampleCount=1.
- Load all 24 indices 0..23, then rewrite index 3 → oAllLoaded=1 after the 24th write; oSampleCount stays 24 after the rewrite; a read of 3 returns the new data.
- Write index 24 and index 0xFFFFFFFF → oLoadError pulses 1 cycle each; count unchanged; the FSM returns to SEQ_IDLE.
- Same-cycle read and write of index 7 (old expected 0xAA, new 0x55) → read returns 0xAA; a read next cycle returns 0x55.
- iClear asserted in WAITING_SAMPLE together with iWriteSample → no write; oSampleCount=0; a read of any index gives oRdLoaded=0, data 0; oNextSample=1 next cycle.
